// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use interlock, taken-branch squash and
// data-memory wait handling with a timeout that parks the pipe in ERR.
module hazard_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt
);

    localparam int unsigned    CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  C_TIMEOUT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_wait_cnt_nxt;
    logic [31:0]     r_stall_cnt;
    logic            r_lu_prev;

    logic            w_lu;
    logic            w_mw;
    logic            w_full_stall;
    logic            w_br_act;
    logic            w_lu_act;

    // The cycle after a load-use bubble the load sits in MEM, so the same pair
    // must not interlock again; forwarding supplies the operand instead.
    assign w_lu = ex_is_load && (ex_rd != 5'd0) && !r_lu_prev &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_mw = mem_req && !mem_ack;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_full_stall   = 1'b0;
        w_br_act       = 1'b0;
        w_lu_act       = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_wait_cnt_nxt = '0;
                if (w_mw) begin
                    w_full_stall   = 1'b1;
                    w_state_nxt    = S_MEM_WAIT;
                    w_wait_cnt_nxt = CW'(1);
                end else if (ex_br_taken) begin
                    w_br_act = 1'b1;
                end else if (w_lu) begin
                    w_lu_act = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (w_mw) begin
                    w_full_stall = 1'b1;
                    if (r_wait_cnt == C_TIMEOUT) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                    end
                end else begin
                    // A dropped request counts as completion.
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                    if (ex_br_taken) begin
                        w_br_act = 1'b1;
                    end else if (w_lu) begin
                        w_lu_act = 1'b1;
                    end
                end
            end
            S_ERR: begin
                w_full_stall = 1'b1;
            end
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
        if (!rst_n) begin
            w_full_stall = 1'b0;
            w_br_act     = 1'b0;
            w_lu_act     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_lu_prev  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_lu_prev  <= w_lu_act;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (pc_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign pc_stall    = w_full_stall | w_lu_act;
    assign ifid_stall  = w_full_stall | w_lu_act;
    assign idex_stall  = w_full_stall;
    assign exmem_stall = w_full_stall;
    assign ifid_flush  = w_br_act;
    assign idex_flush  = w_br_act | w_lu_act;
    assign memwb_flush = w_full_stall;
    assign mem_timeout = (r_state == S_ERR);
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_hazard_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        idUseRs1, idUseRs2, exIsLoad, brTaken, memReq, memAck;
    logic        pcStall, ifidStall, idexStall, exmemStall;
    logic        ifidFlush, idexFlush, memwbFlush, memTimeout;
    logic [31:0] stallCnt;

    int checks = 0;
    int errors = 0;

    // Model state: sticky error, consecutive unacknowledged memory cycles,
    // whether last cycle was a load-use bubble, and the stall-cycle tally.
    logic        mdlErr;
    logic        mdlLuLast;
    int unsigned mdlWaits;
    logic [31:0] mdlStalls;
    logic        luNow;
    logic [7:0]  modelNow;
    logic [7:0]  actVec;

    hazard_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(idRs1), .id_rs2(idRs2),
        .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
        .ex_rd(exRd), .ex_is_load(exIsLoad), .ex_br_taken(brTaken),
        .mem_req(memReq), .mem_ack(memAck),
        .pc_stall(pcStall), .ifid_stall(ifidStall),
        .idex_stall(idexStall), .exmem_stall(exmemStall),
        .ifid_flush(ifidFlush), .idex_flush(idexFlush),
        .memwb_flush(memwbFlush), .mem_timeout(memTimeout),
        .stall_cnt(stallCnt)
    );

    always #5 clk = ~clk;

    // Output vector order: pc, ifid_s, idex_s, exmem_s, ifid_f, idex_f, memwb_f, timeout
    function automatic logic [7:0] modelExpect(input logic rstn, input logic err,
                                               input logic luLast, input logic req,
                                               input logic ack, input logic br,
                                               input logic lu);
        if (!rstn)           return 8'b0000_0000;
        if (err)             return 8'b1111_0011;
        if (req && !ack)     return 8'b1111_0010;
        if (br)              return 8'b0000_1100;
        if (lu && !luLast)   return 8'b1100_0100;
        return 8'b0000_0000;
    endfunction

    assign luNow = exIsLoad && (exRd != 5'd0) &&
                   ((idUseRs1 && idRs1 == exRd) || (idUseRs2 && idRs2 == exRd));
    assign modelNow = modelExpect(rst_n, mdlErr, mdlLuLast, memReq, memAck, brTaken, luNow);
    assign actVec = {pcStall, ifidStall, idexStall, exmemStall,
                     ifidFlush, idexFlush, memwbFlush, memTimeout};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdlErr    <= 1'b0;
            mdlLuLast <= 1'b0;
            mdlWaits  <= 0;
            mdlStalls <= '0;
        end else begin
            if (modelNow[7] && mdlStalls != 32'hFFFF_FFFF) mdlStalls <= mdlStalls + 32'd1;
            mdlLuLast <= (modelNow == 8'b1100_0100);
            if (!mdlErr) begin
                if (memReq && !memAck) begin
                    mdlWaits <= mdlWaits + 1;
                    if (mdlWaits + 1 > TO) mdlErr <= 1'b1;
                end else begin
                    mdlWaits <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("outputs", {24'b0, actVec}, {24'b0, modelNow});
        checkOutput("stall_cnt", stallCnt, mdlStalls);
    end

    task automatic setIdle();
        idRs1 = 0; idRs2 = 0; idUseRs1 = 0; idUseRs2 = 0; exRd = 0;
        exIsLoad = 0; brTaken = 0; memReq = 0; memAck = 0;
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic ld, input logic br, input logic req,
                                 input logic ack);
        @(posedge clk);
        #1;
        idRs1 = rs1; idRs2 = rs2; idUseRs1 = u1; idUseRs2 = u2; exRd = rd;
        exIsLoad = ld; brTaken = br; memReq = req; memAck = ack;
        @(negedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        setIdle();
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        setIdle();
        exIsLoad = 1; exRd = 5; idRs2 = 5; idUseRs2 = 1; memReq = 1;
        #2;
        checkOutput("reset pc_stall", {31'b0, pcStall}, 32'd0);
        checkOutput("reset memwb_flush", {31'b0, memwbFlush}, 32'd0);
        checkOutput("reset stall_cnt", stallCnt, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reset held outputs", {24'b0, actVec}, 32'd0);
        setIdle();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Load-use: one bubble, no repeat for the same pair
        applyStimulus(0, 5, 0, 1, 5, 1, 0, 0, 0);
        checkOutput("lu pc_stall", {31'b0, pcStall}, 32'd1);
        checkOutput("lu ifid_stall", {31'b0, ifidStall}, 32'd1);
        checkOutput("lu idex_flush", {31'b0, idexFlush}, 32'd1);
        checkOutput("lu idex_stall", {31'b0, idexStall}, 32'd0);
        applyStimulus(0, 5, 0, 1, 5, 1, 0, 0, 0);
        checkOutput("lu once", {31'b0, pcStall}, 32'd0);
        checkOutput("lu stall_cnt", stallCnt, 32'd1);

        // Branch beats load-use
        applyStimulus(0, 5, 0, 1, 5, 1, 1, 0, 0);
        checkOutput("br ifid_flush", {31'b0, ifidFlush}, 32'd1);
        checkOutput("br idex_flush", {31'b0, idexFlush}, 32'd1);
        checkOutput("br pc_stall", {31'b0, pcStall}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("br stall_cnt", stallCnt, 32'd1);

        // Load-use variants through rs1 / unused operand / non-load
        applyStimulus(7, 0, 1, 0, 7, 1, 0, 0, 0);
        checkOutput("lu rs1", {31'b0, pcStall}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(7, 0, 0, 0, 7, 1, 0, 0, 0);
        checkOutput("lu unused", {31'b0, pcStall}, 32'd0);
        applyStimulus(7, 7, 1, 1, 7, 0, 0, 0, 0);
        checkOutput("lu not load", {31'b0, pcStall}, 32'd0);

        // Memory wait: three stalled cycles then ack
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("mw pc_stall", {31'b0, pcStall}, 32'd1);
            checkOutput("mw memwb_flush", {31'b0, memwbFlush}, 32'd1);
            checkOutput("mw exmem_stall", {31'b0, exmemStall}, 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("mw ack pc_stall", {31'b0, pcStall}, 32'd0);
        checkOutput("mw ack memwb_flush", {31'b0, memwbFlush}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mw stall_cnt", stallCnt, 32'd3);

        // Ack cycle still honours branch and load-use
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("ack br ifid_flush", {31'b0, ifidFlush}, 32'd1);
        checkOutput("ack br pc_stall", {31'b0, pcStall}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(3, 0, 1, 0, 3, 1, 0, 1, 1);
        checkOutput("ack lu pc_stall", {31'b0, pcStall}, 32'd1);
        checkOutput("ack lu idex_flush", {31'b0, idexFlush}, 32'd1);

        // Dropped request counts as ack
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("req drop pc_stall", {31'b0, pcStall}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("req drop run", {31'b0, idexStall}, 32'd0);

        // Timeout: ERR after TO+1 stalled cycles, sticky until reset
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("to stall", {31'b0, pcStall}, 32'd1);
            checkOutput("to not yet", {31'b0, memTimeout}, 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("to mem_timeout", {31'b0, memTimeout}, 32'd1);
        checkOutput("to stall_cnt", stallCnt, 32'd5);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
        checkOutput("err sticky", {31'b0, memTimeout}, 32'd1);
        checkOutput("err pc_stall", {31'b0, pcStall}, 32'd1);
        checkOutput("err ifid_flush", {31'b0, ifidFlush}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("err async reset outputs", {24'b0, actVec}, 32'd0);
        checkOutput("err async reset stall_cnt", stallCnt, 32'd0);
        setIdle();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // x0 destination and same-cycle ack
        applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("x0 no stall", {31'b0, pcStall}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("same ack pc_stall", {31'b0, pcStall}, 32'd0);
        checkOutput("same ack memwb_flush", {31'b0, memwbFlush}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("same ack run", {31'b0, pcStall}, 32'd0);

        // Reset in the middle of a memory wait
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("mid-wait stall", {31'b0, pcStall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-wait reset pc_stall", {31'b0, pcStall}, 32'd0);
        checkOutput("mid-wait reset exmem_stall", {31'b0, exmemStall}, 32'd0);
        checkOutput("mid-wait reset stall_cnt", stallCnt, 32'd0);
        setIdle();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("post reset idle", {31'b0, pcStall}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        checkOutput("post reset fresh count", {31'b0, memTimeout}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("post reset timeout", {31'b0, memTimeout}, 32'd1);

        @(posedge clk);
        #1;
        setIdle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, means the number of MEM_WAIT cycles without mem_ack before the unit enters ERR.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs1, id_rs2  in  5  ID-stage source register addresses.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  EX-stage destination register.
- ex_is_load  in  1  EX instruction is a load (result not available until WB).
- ex_br_taken  in  1  EX stage resolved a taken branch or jump.
- mem_req  in  1  MEM stage has a data-memory access outstanding.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold the named register.
- ifid_flush, idex_flush, memwb_flush  out  1  load a bubble into the named register.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  32  count of cycles with pc_stall=1.

Function
REQ-003 The FSM SHALL have three states: RUN, MEM_WAIT and ERR.
REQ-004 All stall and flush outputs SHALL be combinational from the current state and inputs, so they take effect in the same cycle.
REQ-005 Load-use hazard (lu) SHALL be true when ex_is_load=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd).
REQ-006 Memory wait (mw) SHALL be true when mem_req=1 and mem_ack=0.
REQ-007 Priority SHALL be ERR, then mw, then ex_br_taken, then lu, then none.
REQ-008 On mw, in RUN or MEM_WAIT, the unit SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush; all other flushes SHALL be 0.
REQ-009 RUN with mw SHALL go to MEM_WAIT and set wait_cnt to 1.
REQ-010 mem_req=1 with mem_ack=1 in the same RUN cycle SHALL produce no stall and stay in RUN.
REQ-011 In MEM_WAIT with mem_ack=1, the unit SHALL deassert all stalls that cycle and go to RUN.
REQ-012 That MEM_WAIT ack cycle SHALL still evaluate ex_br_taken and lu with normal priority.
REQ-013 In MEM_WAIT without ack, wait_cnt SHALL increment and saturate at TIMEOUT.
REQ-014 When wait_cnt==TIMEOUT and mem_ack=0, the next state SHALL be ERR.
REQ-015 mem_req dropping to 0 in MEM_WAIT SHALL be treated as ack: return to RUN.
REQ-016 On ex_br_taken (no mw), the unit SHALL assert ifid_flush=1 and idex_flush=1 with pc_stall=0; lu is suppressed because the ID instruction is discarded.
REQ-017 On lu (no mw, no branch), the unit SHALL assert pc_stall=1, ifid_stall=1 and idex_flush=1 for exactly one cycle.
REQ-018 After a lu stall the load is in MEM, so lu SHALL NOT re-trigger for the same pair; forwarding resolves the operand.
REQ-019 ex_rd==0 SHALL never cause a stall.
REQ-020 In ERR, pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush SHALL be 1 and mem_timeout=1.
REQ-021 ERR SHALL be left only by reset.
REQ-022 stall_cnt SHALL increment on every rising edge where pc_stall=1, saturating at 32'hFFFF_FFFF with no wrap.
REQ-023 wait_cnt width SHALL be clog2(TIMEOUT+1).

Reset
REQ-024 While rst_n=0: state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0, and all stall/flush outputs SHALL be forced to 0 regardless of inputs.
REQ-025 Reset SHALL act asynchronously, including mid-MEM_WAIT and in ERR.
REQ-026 The first rising edge after release SHALL be evaluated from RUN.

Verification
REQ-027 Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_stall=ifid_stall=idex_flush=1; stall_cnt becomes 1.
REQ-028 Branch beats load-use: ex_br_taken=1 with the REQ-027 inputs -> ifid_flush=idex_flush=1, pc_stall=0, stall_cnt unchanged.
REQ-029 Memory wait: mem_req=1, mem_ack held low 3 cycles then high -> 3 cycles of full stall plus memwb_flush, then RUN; stall_cnt=3.
REQ-030 Timeout: TIMEOUT=4, mem_req=1, mem_ack=0 -> ERR after 5 stall cycles; mem_timeout=1 and stays set until rst_n=0.
REQ-031 x0 and same-cycle ack: ex_is_load=1, ex_rd=0, id_rs1=0 -> no stall; mem_req=mem_ack=1 in RUN -> no stall.
REQ-032 Reset mid-wait: rst_n low during MEM_WAIT -> outputs 0 immediately, stall_cnt=0, state RUN after release.
